// File: rtl/input_controller.sv
// rtl/input_controller.sv - IN instruction sequencer: stall, debounced confirm press, switch capture
module input_controller #(
   parameter int DEBOUNCE_CYCLES = 500000,
   parameter int VAL_W           = 18
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_req,
   input  logic [1:0]       ext_dec,
   input  logic             btn,
   input  logic [VAL_W-1:0] sw,
   output logic             stall,
   output logic             in_valid,
   output logic [VAL_W-1:0] valor,
   output logic [1:0]       ext,
   output logic             waiting
);

   localparam int            CW       = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

   if (DEBOUNCE_CYCLES < 2) begin : g_bad_debounce
      $error("input_controller: DEBOUNCE_CYCLES must be at least 2");
   end

   typedef enum logic [2:0] {
      IDLE,
      WAIT_PRESS,
      DEBOUNCE,
      DONE,
      WAIT_RELEASE
   } state_t;

   state_t           state, state_next;
   logic [CW-1:0]    cnt, cnt_next;
   logic             load;
   logic             btn_m, btn_s;
   logic [VAL_W-1:0] sw_m, sw_s;

   // Two-flop synchronisers for the asynchronous button and switch pins
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         btn_m <= 1'b0;
         btn_s <= 1'b0;
         sw_m  <= '0;
         sw_s  <= '0;
      end else begin
         btn_m <= btn;
         btn_s <= btn_m;
         sw_m  <= sw;
         sw_s  <= sw_m;
      end
   end

   // Next-state and debounce counter logic
   always_comb begin
      state_next = state;
      cnt_next   = cnt;
      load       = 1'b0;
      case (state)
         IDLE: begin
            if (in_req) state_next = WAIT_PRESS;
         end
         WAIT_PRESS: begin
            if (!in_req) begin
               state_next = IDLE;
               cnt_next   = '0;
            end else if (btn_s) begin
               state_next = DEBOUNCE;
               cnt_next   = CW'(1);
            end
         end
         DEBOUNCE: begin
            if (!in_req) begin
               state_next = IDLE;
               cnt_next   = '0;
            end else if (!btn_s) begin
               state_next = WAIT_PRESS;
               cnt_next   = '0;
            end else if (cnt == CNT_LAST) begin
               state_next = DONE;
               load       = 1'b1;
            end else begin
               cnt_next = cnt + CW'(1);
            end
         end
         DONE: begin
            state_next = WAIT_RELEASE;
            cnt_next   = '0;
         end
         WAIT_RELEASE: begin
            // in_req is deliberately ignored: a held button must never re-trigger
            if (btn_s) begin
               cnt_next = '0;
            end else if (cnt == CNT_LAST) begin
               state_next = IDLE;
               cnt_next   = '0;
            end else begin
               cnt_next = cnt + CW'(1);
            end
         end
         default: begin
            state_next = IDLE;
            cnt_next   = '0;
         end
      endcase
   end

   // State, counter, captured value and registered status outputs
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= IDLE;
         cnt      <= '0;
         valor    <= '0;
         in_valid <= 1'b0;
         waiting  <= 1'b0;
      end else begin
         state    <= state_next;
         cnt      <= cnt_next;
         if (load) valor <= sw_s;
         in_valid <= (state_next == DONE);
         waiting  <= (state_next == WAIT_PRESS) || (state_next == DEBOUNCE);
      end
   end

   // The core is released during DONE so it can perform the write-back
   assign stall = in_req & (state != DONE);
   assign ext   = (state == DONE) ? 2'b10 : ext_dec;

endmodule

// File: tb/tb_input_controller.sv
// tb/tb_input_controller.sv - self-checking bench for input_controller
module tb_input_controller;

   localparam int DC = 4;
   localparam int W  = 18;

   logic         clk = 1'b0;
   logic         rst;
   logic         in_req;
   logic [1:0]   ext_dec;
   logic         btn;
   logic [W-1:0] sw;
   logic         stall;
   logic         in_valid;
   logic [W-1:0] valor;
   logic [1:0]   ext;
   logic         waiting;

   input_controller #(.DEBOUNCE_CYCLES(DC), .VAL_W(W)) dut (
      .clk      (clk),
      .rst      (rst),
      .in_req   (in_req),
      .ext_dec  (ext_dec),
      .btn      (btn),
      .sw       (sw),
      .stall    (stall),
      .in_valid (in_valid),
      .valor    (valor),
      .ext      (ext),
      .waiting  (waiting)
   );

   always #5 clk = ~clk;

   // Reference: "phase" of the transfer plus a run length of consecutive
   // identical button samples; a transfer completes after DC highs, and the
   // next one may begin only after DC consecutive lows.
   typedef enum {M_IDLE, M_WAIT, M_DONE, M_REL} mode_t;
   mode_t        m_mode;
   int           m_run;
   logic [W-1:0] m_val;
   logic         b1, b2;
   logic [W-1:0] s1, s2;

   int n_cmp = 0;
   int n_err = 0;
   int pulses = 0;
   int p0;
   logic [W-1:0] saved;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      assert (got === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_mode = M_IDLE;
      m_run  = 0;
      m_val  = '0;
      b1 = 1'b0; b2 = 1'b0;
      s1 = '0;   s2 = '0;
   endtask

   task automatic model_edge();
      case (m_mode)
         M_IDLE: if (in_req) begin m_mode = M_WAIT; m_run = 0; end
         M_WAIT: begin
            if (!in_req) m_mode = M_IDLE;
            else if (b2) begin
               m_run++;
               if (m_run == DC) begin m_mode = M_DONE; m_val = s2; end
            end else m_run = 0;
         end
         M_DONE: begin m_mode = M_REL; m_run = 0; end
         M_REL: begin
            if (b2) m_run = 0;
            else begin
               m_run++;
               if (m_run == DC) begin m_mode = M_IDLE; m_run = 0; end
            end
         end
         default: m_mode = M_IDLE;
      endcase
      b2 = b1; b1 = btn;
      s2 = s1; s1 = sw;
   endtask

   task automatic check_all();
      chk("stall",    32'(stall),    32'(in_req && (m_mode != M_DONE)));
      chk("ext",      32'(ext),      (m_mode == M_DONE) ? 32'd2 : 32'(ext_dec));
      chk("in_valid", 32'(in_valid), 32'(m_mode == M_DONE));
      chk("waiting",  32'(waiting),  32'(m_mode == M_WAIT));
      chk("valor",    32'(valor),    32'(m_val));
      if (in_valid) pulses++;
   endtask

   task automatic tick();
      @(posedge clk);
      if (rst) model_reset(); else model_edge();
      @(negedge clk);
      check_all();
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic wait_pulse(input int max);
      int k;
      k = 0;
      while (!in_valid && k < max) begin
         tick();
         k++;
      end
      chk("pulse_within_bound", 32'(in_valid), 32'd1);
   endtask

   initial begin
      rst = 1'b1; in_req = 1'b0; btn = 1'b0; sw = '0; ext_dec = 2'b00;
      model_reset();
      #1;
      chk("rst_valor",    32'(valor),    32'd0);
      chk("rst_in_valid", 32'(in_valid), 32'd0);
      chk("rst_waiting",  32'(waiting),  32'd0);
      chk("rst_stall0",   32'(stall),    32'd0);
      in_req = 1'b1; ext_dec = 2'b01;
      #1;
      chk("rst_stall1",   32'(stall),    32'd1);
      chk("rst_ext",      32'(ext),      32'd1);
      in_req = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      ticks(3);

      // Basic capture
      sw = 18'h2ABCD; ext_dec = 2'b01; in_req = 1'b1;
      ticks(3);
      chk("basic_stall_before", 32'(stall), 32'd1);
      btn = 1'b1;
      p0 = pulses;
      wait_pulse(20);
      chk("basic_valor", 32'(valor), 32'h2ABCD);
      chk("basic_ext",   32'(ext),   32'd2);
      chk("basic_stall_in_done", 32'(stall), 32'd0);
      in_req = 1'b0; btn = 1'b0;
      ticks(8);
      chk("basic_one_pulse", 32'(pulses - p0), 32'd1);

      // Bounce: pin 1,1,0,1,1,1,1 then held
      in_req = 1'b1; sw = 18'h0155A;
      ticks(2);
      p0 = pulses;
      for (int i = 0; i < 7; i++) begin
         btn = (i == 2) ? 1'b0 : 1'b1;
         tick();
         chk("bounce_no_early_pulse", 32'(in_valid), 32'd0);
      end
      wait_pulse(10);
      chk("bounce_valor", 32'(valor), 32'h0155A);
      in_req = 1'b0;
      ticks(3);
      chk("bounce_one_pulse", 32'(pulses - p0), 32'd1);

      // Held button: new request must not capture until released
      in_req = 1'b1; sw = 18'h00777;
      p0 = pulses;
      for (int i = 0; i < 12; i++) begin
         tick();
         chk("held_stall", 32'(stall), 32'd1);
      end
      chk("held_no_pulse", 32'(pulses - p0), 32'd0);
      btn = 1'b0;
      ticks(8);
      btn = 1'b1;
      wait_pulse(20);
      chk("held_new_valor", 32'(valor), 32'h00777);
      in_req = 1'b0; btn = 1'b0;
      ticks(8);
      chk("held_one_pulse", 32'(pulses - p0), 32'd1);

      // Flush in DEBOUNCE
      saved = valor;
      sw = 18'h12345; in_req = 1'b1;
      ticks(2);
      btn = 1'b1;
      ticks(3);
      chk("flush_waiting", 32'(waiting), 32'd1);
      in_req = 1'b0; ext_dec = 2'b11;
      #1;
      chk("flush_ext", 32'(ext), 32'd3);
      chk("flush_stall", 32'(stall), 32'd0);
      tick();
      chk("flush_idle", 32'(waiting), 32'd0);
      chk("flush_valor_kept", 32'(valor), 32'(saved));
      btn = 1'b0;
      ticks(6);

      // Asynchronous reset mid-DEBOUNCE
      in_req = 1'b1; ext_dec = 2'b00; sw = 18'h0ABCD;
      ticks(2);
      btn = 1'b1;
      ticks(3);
      chk("rstmid_waiting_before", 32'(waiting), 32'd1);
      #2;
      rst = 1'b1;
      #1;
      model_reset();
      chk("rstmid_valor",    32'(valor),    32'd0);
      chk("rstmid_in_valid", 32'(in_valid), 32'd0);
      chk("rstmid_waiting",  32'(waiting),  32'd0);
      chk("rstmid_ext",      32'(ext),      32'd0);
      chk("rstmid_stall",    32'(stall),    32'd1);
      in_req = 1'b0; btn = 1'b0; ext_dec = 2'b01;
      @(negedge clk);
      rst = 1'b0;
      tick();
      chk("rstmid_ext_after", 32'(ext), 32'd1);
      ticks(4);

      // Negative value
      sw = 18'h3FFFF; in_req = 1'b1;
      ticks(2);
      btn = 1'b1;
      wait_pulse(20);
      chk("neg_valor", 32'(valor), 32'h3FFFF);
      chk("neg_sext", {{(32-W){valor[W-1]}}, valor}, 32'hFFFFFFFF);
      in_req = 1'b0; btn = 1'b0;
      ticks(8);

      // Randomised traffic against the reference
      for (int i = 0; i < 1500; i++) begin
         if ($urandom_range(5) == 0) btn = ~btn;
         if ($urandom_range(2) == 0) sw = W'($urandom);
         ext_dec = 2'($urandom);
         if (in_valid) in_req = 1'b0;
         else if (!in_req) in_req = ($urandom_range(3) == 0);
         else if ($urandom_range(39) == 0) in_req = 1'b0;
         tick();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
